// File: rtl/fetch_pc_reg_pkg.sv
// Shared types and constants for the fetch-stage PC register.
//   word_t          : 32-bit machine word
//   RESET_PC_DEFAULT: boot vector loaded on reset
//   fetch_state_t   : bus-handshake state (REQ / WAIT / DROP)
//   fetch_buf_t     : one-entry fetched-instruction buffer toward decode
package fetch_pc_reg_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'hbfc0_0000;
  localparam word_t PC_STEP          = 32'd4;

  // REQ : may issue a request for pcF (or raise an ADEL entry when misaligned)
  // WAIT: request accepted, waiting for read data
  // DROP: request was flushed by an exception, swallow its late response
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t pc;
    word_t instr;
    logic  adel;
  } fetch_buf_t;

  localparam fetch_buf_t FETCH_BUF_RESET = '{
    valid: 1'b0,
    pc:    32'h0000_0000,
    instr: 32'h0000_0000,
    adel:  1'b0
  };

  // A fetch address must be word aligned; anything else is an address error.
  function automatic logic pc_misaligned(input word_t pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch-stage PC register and instruction-memory front end.
//
// Owns pcF, issues single-outstanding requests on the addr_ok/data_ok bus,
// and holds one fetched instruction for decode. Redirects honour the MIPS
// delay slot: the instruction at pcF is always fetched before the target.
// Exception flushes override everything and drop an in-flight response.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   pc_new, redirect       taken branch/jump target from next-PC select
//   exc_valid, exc_pc      exception/eret flush and its target
//   stall                  decode not ready (buffer consumed when !stall)
//   pcplus4F               pcF + 4 (combinational)
//   inst_req, inst_addr    request valid and address (= pcF)
//   inst_addr_ok           request accepted this cycle
//   inst_data_ok, inst_rdata  read data returned this cycle
//   out_valid/out_pc/out_instr/out_adel  buffered entry toward decode
module fetch_pc_reg
  import fetch_pc_reg_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pc_new,
  input  logic        redirect,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        stall,
  output logic [31:0] pcplus4F,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_adel
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  logic         pend_valid_q, pend_valid_d;
  word_t        pend_pc_q, pend_pc_d;
  fetch_buf_t   buf_q, buf_d;

  logic  buf_free_s;
  logic  misaligned_s;
  logic  inst_req_s;
  logic  cap_data_s;
  logic  cap_adel_s;
  logic  capture_s;
  word_t pc_plus4_s;
  word_t next_seq_pc_s;

  assign pc_plus4_s = pc_q + PC_STEP;

  // Request gating and decode of which capture (bus data or ADEL) happens now.
  always_comb begin
    buf_free_s   = !buf_q.valid || !stall;
    misaligned_s = pc_misaligned(pc_q);
    inst_req_s   = 1'b0;
    cap_data_s   = 1'b0;
    cap_adel_s   = 1'b0;
    case (state_q)
      REQ: begin
        // A request is only issued when its data is guaranteed a free slot,
        // so a later capture never has to wait on decode.
        if (resetn && buf_free_s && !misaligned_s && !exc_valid) begin
          inst_req_s = 1'b1;
        end else begin
          inst_req_s = 1'b0;
        end
        // A misaligned PC never reaches the bus; it becomes an ADEL entry.
        if (buf_free_s && misaligned_s && !exc_valid) begin
          cap_adel_s = 1'b1;
        end else begin
          cap_adel_s = 1'b0;
        end
        // Memory may return data in the same cycle it accepts the address.
        cap_data_s = inst_req_s && inst_addr_ok && inst_data_ok;
      end
      WAIT: begin
        cap_data_s = inst_data_ok && !exc_valid;
      end
      DROP: begin
        cap_data_s = 1'b0;
        cap_adel_s = 1'b0;
      end
      default: begin
        cap_data_s = 1'b0;
        cap_adel_s = 1'b0;
      end
    endcase
    capture_s = cap_data_s || cap_adel_s;
  end

  // Sequential successor of pcF: a latched redirect wins, then a redirect
  // arriving in the capture cycle, otherwise fall through to pcF + 4.
  always_comb begin
    next_seq_pc_s = pc_plus4_s;
    if (pend_valid_q) begin
      next_seq_pc_s = pend_pc_q;
    end else if (redirect) begin
      next_seq_pc_s = pc_new;
    end else begin
      next_seq_pc_s = pc_plus4_s;
    end
  end

  // Next-state computation for pcF, the pending redirect, buffer and FSM.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    buf_d        = buf_q;

    // Decode drains the buffer; a capture below may refill it in the same cycle.
    if (buf_q.valid && !stall) begin
      buf_d.valid = 1'b0;
    end else begin
      buf_d.valid = buf_q.valid;
    end

    if (exc_valid) begin
      pc_d         = exc_pc;
      buf_d.valid  = 1'b0;
      pend_valid_d = 1'b0;
    end else if (capture_s) begin
      // pcF's instruction (the delay slot, if a redirect is in play) is now
      // captured, so the redirect target, if any, takes effect here.
      pc_d         = next_seq_pc_s;
      pend_valid_d = 1'b0;
      buf_d.valid  = 1'b1;
      buf_d.pc     = pc_q;
      buf_d.instr  = cap_data_s ? inst_rdata : 32'h0000_0000;
      buf_d.adel   = cap_adel_s;
    end else if (redirect) begin
      // Delay slot not captured yet: remember the target until it is.
      pend_valid_d = 1'b1;
      pend_pc_d    = pc_new;
    end else begin
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;
    end

    case (state_q)
      REQ: begin
        // Same-cycle addr_ok/data_ok completes the access without leaving REQ.
        if (inst_req_s && inst_addr_ok && !inst_data_ok) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          state_d = REQ;
        end else if (exc_valid) begin
          state_d = DROP;
        end else begin
          state_d = WAIT;
        end
      end
      DROP: begin
        if (inst_data_ok) begin
          state_d = REQ;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0000_0000;
      buf_q        <= FETCH_BUF_RESET;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      buf_q        <= buf_d;
    end
  end

  assign pcplus4F  = pc_plus4_s;
  assign inst_req  = inst_req_s;
  assign inst_addr = pc_q;
  assign out_valid = buf_q.valid;
  assign out_pc    = buf_q.pc;
  assign out_instr = buf_q.instr;
  assign out_adel  = buf_q.adel;

endmodule
